mem_arbiter: RTL and testbench

//  Shares the single data-memory port (addr/wdata/is_store/store_load_type/loaddata) between
//  two requesters: port 0 = instruction fetch, port 1 = load/store unit. Per-port valid/ready

---
 rtl/mem_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose  : shares one data-memory port between instruction fetch (port 0) and the load/store unit (port 1).
// Latency  : request accepted at cycle t -> memory access at t+1 -> response valid at t+2; next accept at t+3 at the earliest.
// Backpress: a response is held, data stable, until rspN_ready; no request is accepted until then (reqN_ready=0 outside IDLE).
//
// Ports (N = 0, 1):
//   clk, rst                 clock and asynchronous active-high reset
//   reqN_valid/reqN_ready    request handshake; reqN_addr/_wdata/_is_store/_type request payload
//   rspN_valid/rspN_ready    response handshake; rspN_rdata captured load data (0 for stores)
//   mem_addr/_wdata/_type    memory request fields, driven only during the ACCESS cycle, 0 otherwise
//   mem_is_store             memory write strobe, high only during ACCESS
//   mem_loaddata             combinational read data returned by the memory
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties. Without it,
// port 1 wins ties, except that port 0 is forced through after STARVE_LIMIT consecutive losses.

module mem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    input  logic              req0_is_store,
    input  logic [2:0]        req0_type,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [31:0]       rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    input  logic              req1_is_store,
    input  logic [2:0]        req1_type,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [31:0]       rsp1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_is_store,
    output logic [2:0]        mem_type,
    input  logic [31:0]       mem_loaddata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,    state_d;
    logic              owner_q,    owner_d;     // port that owns the in-flight transaction
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        type_q,     type_d;
    logic [31:0]       rdata_q,    rdata_d;

`ifdef MEM_ARB_RR_EN
    logic              rr_last_q,  rr_last_d;   // port granted by the most recent accept
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              starve_hit;
`endif

    // ------------------------------------------------------------------
    // Arbitration (combinational, only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic grant0, grant1;
    logic acc0, acc1;
    logic in_idle, in_access, in_resp;

    assign in_idle   = (state_q == S_IDLE);
    assign in_access = (state_q == S_ACCESS);
    assign in_resp   = (state_q == S_RESP);

`ifndef MEM_ARB_RR_EN
    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_RR_EN
            // The port that did not win last time takes the tie.
            grant0 = rr_last_q;
            grant1 = ~rr_last_q;
`else
            // Port 1 normally wins ties; port 0 is let through once it has lost too often.
            grant0 = starve_hit;
            grant1 = ~starve_hit;
`endif
        end else begin
            // A lone requester always wins, whatever the priority state says.
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign req0_ready = ~rst & in_idle & grant0;
    assign req1_ready = ~rst & in_idle & grant1;

    assign acc0 = req0_valid & req0_ready;
    assign acc1 = req1_valid & req1_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_store_d = is_store_q;
        type_d     = type_q;
        rdata_d    = rdata_q;
`ifdef MEM_ARB_RR_EN
        rr_last_d  = rr_last_q;
`else
        starve_cnt_d = starve_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (acc0 || acc1) begin
                    state_d    = S_ACCESS;
                    owner_d    = acc1;
                    addr_d     = acc1 ? req1_addr     : req0_addr;
                    wdata_d    = acc1 ? req1_wdata    : req0_wdata;
                    is_store_d = acc1 ? req1_is_store : req0_is_store;
                    type_d     = acc1 ? req1_type     : req0_type;
`ifdef MEM_ARB_RR_EN
                    rr_last_d  = acc1;
`else
                    // Count only real losses: port 0 asking while port 1 is granted.
                    if (acc0) begin
                        starve_cnt_d = '0;
                    end else if (req0_valid && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
`endif
                end
            end

            S_ACCESS: begin
                // Memory read is combinational; capture it at the end of the access cycle.
                rdata_d = is_store_q ? 32'h0 : mem_loaddata;
                state_d = S_RESP;
            end

            S_RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            is_store_q <= 1'b0;
            type_q     <= 3'h0;
            rdata_q    <= 32'h0;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= 1'b0;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_store_q <= is_store_d;
            type_q     <= type_d;
            rdata_q    <= rdata_d;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Memory fields are forced to 0 outside ACCESS so a stale latched store can never
    // write; because state_q resets asynchronously, a reset mid-access drops the strobe at once.
    assign mem_addr     = in_access ? addr_q  : '0;
    assign mem_wdata    = in_access ? wdata_q : 32'h0;
    assign mem_is_store = in_access & is_store_q;
    assign mem_type     = in_access ? type_q  : 3'h0;

    assign rsp0_valid = in_resp & ~owner_q;
    assign rsp1_valid = in_resp &  owner_q;
    assign rsp0_rdata = rsp0_valid ? rdata_q : 32'h0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose  : directed bench for mem_arbiter with a behavioural word memory.
// Latency  : checks handshake at t, access at t+1, response at t+2.
// Backpress: exercises held responses and reset during a store access.

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_is_store, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, req1_is_store, rsp1_valid, rsp1_ready;
    logic [13:0] req0_addr, req1_addr, mem_addr;
    logic [31:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, mem_wdata, mem_loaddata;
    logic [2:0]  req0_type, req1_type, mem_type;
    logic        mem_is_store;

    int n_cmp = 0;
    int n_bad = 0;
    int store_pulses = 0;

    logic [31:0] mem [0:16383];

    mem_arbiter #(.ADDR_W(14), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_is_store(req0_is_store), .req0_type(req0_type),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_is_store(req1_is_store), .req1_type(req1_type),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_is_store(mem_is_store),
        .mem_type(mem_type), .mem_loaddata(mem_loaddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write on the falling edge of the access cycle.
    assign mem_loaddata = mem[mem_addr];
    always @(negedge clk) begin
        if (mem_is_store) begin
            mem[mem_addr] <= mem_wdata;
            store_pulses  <= store_pulses + 1;
        end
    end

    typedef struct {
        logic        port;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic        st;
        logic [2:0]  typ;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic [13:0] a,
                         input logic [31:0] d, input logic s, input logic [2:0] t);
        if (p == 0) begin
            req0_valid = v; req0_addr = a; req0_wdata = d; req0_is_store = s; req0_type = t;
        end else begin
            req1_valid = v; req1_addr = a; req1_wdata = d; req1_is_store = s; req1_type = t;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic r);
        if (p == 0) rsp0_ready = r;
        else        rsp1_ready = r;
    endtask

    function automatic logic ready_of(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rvalid_of(input int p);
        return (p == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? rsp0_rdata : rsp1_rdata;
    endfunction

    // One complete transaction from the vector table, with cycle-exact checks.
    task automatic do_txn(input int idx);
        vec_t v;
        int   p;
        int   pulses0;
        v = vecs[idx];
        p = int'(v.port);
        @(posedge clk); #1;
        drive(p, 1'b1, v.addr, v.wdata, v.st, v.typ);
        set_rsp_ready(p, 1'b1);
        @(negedge clk);
        check($sformatf("v%0d req_ready", idx), 32'(ready_of(p)), 32'd1);
        check($sformatf("v%0d other_ready", idx), 32'(ready_of(1 - p)), 32'd0);
        @(posedge clk); #1;
        drive(p, 1'b0, 14'h0, 32'h0, 1'b0, 3'h0);
        pulses0 = store_pulses;
        @(negedge clk);
        check($sformatf("v%0d mem_is_store", idx), 32'(mem_is_store), 32'(v.st));
        check($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.addr));
        check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        check($sformatf("v%0d mem_type", idx), 32'(mem_type), 32'(v.typ));
        check($sformatf("v%0d early_rsp", idx), 32'(rvalid_of(p)), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("v%0d rsp_valid", idx), 32'(rvalid_of(p)), 32'd1);
        check($sformatf("v%0d other_rsp", idx), 32'(rvalid_of(1 - p)), 32'd0);
        check($sformatf("v%0d rdata", idx), rdata_of(p), v.exp_rdata);
        check($sformatf("v%0d resp_mem_idle", idx), 32'({mem_is_store, mem_addr}), 32'd0);
        @(posedge clk); #1;
        set_rsp_ready(p, 1'b0);
        check($sformatf("v%0d store_pulses", idx), 32'(store_pulses - pulses0), 32'(v.st));
        check($sformatf("v%0d rsp_dropped", idx), 32'(rvalid_of(p)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   grants [10];
        int   exp_grants [10];
        int   ng;
        int   pulses0;

        for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
        mem[14'h0010] <= 32'hDEADBEEF;
        mem[14'h0030] <= 32'h11111111;

        //            port  addr      wdata          st    typ     exp_rdata
        vecs[0] = '{1'b0, 14'h0010, 32'h00000000, 1'b0, 3'b010, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 14'h0020, 32'h12345678, 1'b1, 3'b010, 32'h00000000};
        vecs[2] = '{1'b0, 14'h0020, 32'h00000000, 1'b0, 3'b010, 32'h12345678};
        vecs[3] = '{1'b1, 14'h0010, 32'h0BADF00D, 1'b0, 3'b100, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 14'h3FFF, 32'hAAAA5555, 1'b1, 3'b000, 32'h00000000};
        vecs[5] = '{1'b1, 14'h3FFF, 32'h00000000, 1'b0, 3'b101, 32'hAAAA5555};
        vecs[6] = '{1'b1, 14'h0000, 32'hFFFFFFFF, 1'b1, 3'b001, 32'h00000000};
        vecs[7] = '{1'b0, 14'h0000, 32'h00000000, 1'b0, 3'b010, 32'hFFFFFFFF};

`ifdef MEM_ARB_RR_EN
        exp_grants = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp_grants = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif

        rst = 1'b1;
        drive(0, 1'b0, 14'h0, 32'h0, 1'b0, 3'h0);
        drive(1, 1'b0, 14'h0, 32'h0, 1'b0, 3'h0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("rst rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        check("rst mem_ctl", 32'({mem_is_store, mem_type, mem_addr}), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Single transactions from the table
        for (int i = 0; i < 8; i++) do_txn(i);

        // Both ports continuously valid, starting from a fresh reset
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b1, 14'h0010, 32'h0, 1'b0, 3'b010);
        drive(1, 1'b1, 14'h0010, 32'h0, 1'b0, 3'b010);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        ng = 0;
        for (int cyc = 0; cyc < 100 && ng < 10; cyc++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) begin
                check("arb both_ready", 32'd1, 32'd0);
            end
            if (req0_ready) begin
                grants[ng] = 0; ng++;
            end else if (req1_ready) begin
                grants[ng] = 1; ng++;
            end
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 14'h0, 32'h0, 1'b0, 3'h0);
        drive(1, 1'b0, 14'h0, 32'h0, 1'b0, 3'h0);
        check("arb grant_count", 32'(ng), 32'd10);
        for (int i = 0; i < ng; i++) begin
            check($sformatf("arb grant%0d", i), 32'(grants[i]), 32'(exp_grants[i]));
        end
        repeat (3) @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Held response: port 1 stalls its response for five cycles
        drive(1, 1'b1, 14'h0010, 32'h0, 1'b0, 3'b010);
        @(negedge clk);
        check("bp req1_ready", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        drive(1, 1'b0, 14'h0, 32'h0, 1'b0, 3'h0);
        drive(0, 1'b1, 14'h0020, 32'h0, 1'b0, 3'b010);
        @(negedge clk);
        check("bp access req0_ready", 32'(req0_ready), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d rsp1_valid", i), 32'(rsp1_valid), 32'd1);
            check($sformatf("bp%0d rsp1_rdata", i), rsp1_rdata, 32'hDEADBEEF);
            check($sformatf("bp%0d req0_ready", i), 32'(req0_ready), 32'd0);
            check($sformatf("bp%0d rsp0_valid", i), 32'(rsp0_valid), 32'd0);
            @(posedge clk); #1;
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("bp release rsp1_valid", 32'(rsp1_valid), 32'd1);
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp after req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 14'h0, 32'h0, 1'b0, 3'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp port0 rsp_valid", 32'(rsp0_valid), 32'd1);
        check("bp port0 rdata", rsp0_rdata, 32'h12345678);
        @(posedge clk); #1;
        rsp0_ready = 1'b0;

        // Reset asserted in the middle of a store access
        drive(0, 1'b1, 14'h0030, 32'hCAFE0000, 1'b1, 3'b010);
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("rstmid req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 14'h0, 32'h0, 1'b0, 3'h0);
        pulses0 = store_pulses;
        #1;
        check("rstmid access store", 32'(mem_is_store), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid store_dropped", 32'(mem_is_store), 32'd0);
        check("rstmid mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rstmid%0d rsp_valid", i), 32'({rsp0_valid, rsp1_valid}), 32'd0);
        end
        check("rstmid mem_untouched", mem[14'h0030], 32'h11111111);
        check("rstmid no_pulse", 32'(store_pulses - pulses0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
